// File: rtl/psram_bus_bridge_pkg.sv
// rtl/psram_bus_bridge_pkg.sv - shared types and constants for the PSRAM bus bridge
package psram_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_WAIT,
      WR_CMD,
      WR_WAIT,
      DONE
   } state_t;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

   localparam logic [3:0]  MASK_NONE = 4'b1111;
   localparam logic [3:0]  MASK_WORD = 4'b0011;
   localparam logic [15:0] ERR_DATA  = 16'hFFFF;

   // CPU data sits in the upper half of the 32-bit word; a0 picks the byte lane.
   function automatic logic [3:0] byte_mask(input logic byte_wr, input logic a0);
      return byte_wr ? {~a0, a0, 2'b11} : MASK_WORD;
   endfunction

endpackage

// File: rtl/psram_bus_bridge_if.sv
// rtl/psram_bus_bridge_if.sv - CPU strobe side and multi-channel PSRAM controller side of the bridge
interface psram_bus_bridge_if #(
   parameter int NCH    = 2,
   parameter int ADDR_W = 23,
   parameter int MC_AW  = 21
);
   logic                  req_rd;
   logic                  req_wr;
   logic                  req_byte;
   logic [ADDR_W-1:0]     req_addr;
   logic [15:0]           req_wdata;
   logic [15:0]           rdata;
   logic                  ack;
   logic                  err;
   logic                  init;
   logic [NCH-1:0]        mc_cmd;
   logic [NCH-1:0]        mc_cmd_en;
   logic [NCH*MC_AW-1:0]  mc_addr;
   logic [NCH*32-1:0]     mc_wr_data;
   logic [NCH*4-1:0]      mc_data_mask;
   logic [NCH*32-1:0]     mc_rd_data;
   logic [NCH-1:0]        mc_rd_valid;
   logic [NCH-1:0]        mc_init_calib;

   modport slave (
      input  req_rd, req_wr, req_byte, req_addr, req_wdata,
      input  mc_rd_data, mc_rd_valid, mc_init_calib,
      output rdata, ack, err, init,
      output mc_cmd, mc_cmd_en, mc_addr, mc_wr_data, mc_data_mask
   );

   modport master (
      output req_rd, req_wr, req_byte, req_addr, req_wdata,
      output mc_rd_data, mc_rd_valid, mc_init_calib,
      input  rdata, ack, err, init,
      input  mc_cmd, mc_cmd_en, mc_addr, mc_wr_data, mc_data_mask
   );
endinterface

// File: rtl/psram_bus_bridge_req_sync.sv
// rtl/psram_bus_bridge_req_sync.sv - level synchroniser for the asynchronous CPU strobes
module psram_req_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_out,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] r_sync;

   if (STAGES == 1) begin : g_one
      always_ff @(posedge clk_out or negedge rst_n) begin
         if (!rst_n) r_sync <= '0;
         else        r_sync <= i_d;
      end
   end else begin : g_chain
      always_ff @(posedge clk_out or negedge rst_n) begin
         if (!rst_n) r_sync <= '0;
         else        r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/psram_bus_bridge.sv
// rtl/psram_bus_bridge.sv - DCJ11 strobe bus to multi-channel PSRAM controller bridge
module psram_bus_bridge
   import psram_bridge_pkg::*;
#(
   parameter int NCH         = 2,
   parameter int ADDR_W      = 23,
   parameter int MC_AW       = 21,
   parameter int SYNC_STAGES = 2,
   parameter int BURST_BEATS = 4,
   parameter int WR_HOLD     = 13,
   parameter int RD_TIMEOUT  = 63
) (
   input  logic             clk_out,
   input  logic             rst_n,
   psram_bus_bridge_if.slave bus
);
   localparam int TMAX = (WR_HOLD > RD_TIMEOUT) ? WR_HOLD : RD_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int BW   = $clog2(BURST_BEATS + 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);
   localparam logic [TW-1:0] RD_LIMIT  = TW'(RD_TIMEOUT - 1);
   localparam logic [TW-1:0] WR_LIMIT  = TW'(WR_HOLD - 1);

   logic w_rd_s, w_wr_s;

   psram_req_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
      .clk_out (clk_out), .rst_n (rst_n), .i_d (bus.req_rd), .o_q (w_rd_s)
   );
   psram_req_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
      .clk_out (clk_out), .rst_n (rst_n), .i_d (bus.req_wr), .o_q (w_wr_s)
   );

   state_t           r_state, w_next;
   logic             r_ch, r_dir, r_byte, r_a0;
   logic [MC_AW-1:0] r_addr;
   logic [15:0]      r_wdata, r_rdata;
   logic             r_ack, r_err;
   logic [TW-1:0]    r_timer;
   logic [BW-1:0]    r_beats;

   logic        w_ch_valid [NCH];
   logic        w_ch_calib [NCH];
   logic [15:0] w_ch_rdata [NCH];

   logic        w_init, w_req_ch, w_busy, w_abort, w_beat, w_last, w_strobe;
   logic        w_timeout, w_wr_end;
   logic [15:0] w_beat_data;
   logic        w_cmd_en, w_drive, w_wr_drive;
   logic [3:0]  w_mask;

   assign w_init      = &bus.mc_init_calib;
   assign w_req_ch    = (NCH == 2) ? bus.req_addr[ADDR_W-1] : 1'b0;
   assign w_busy      = (r_state == RD_CMD) || (r_state == RD_WAIT) ||
                        (r_state == WR_CMD) || (r_state == WR_WAIT);
   assign w_abort     = w_busy && !w_ch_calib[r_ch];
   assign w_beat      = w_ch_valid[r_ch];
   assign w_beat_data = w_ch_rdata[r_ch];
   assign w_last      = w_beat && (r_beats == LAST_BEAT);
   assign w_timeout   = (r_timer == RD_LIMIT);
   assign w_wr_end    = (r_timer == WR_LIMIT);
   assign w_strobe    = (r_dir == CMD_WR) ? w_wr_s : w_rd_s;

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_init && w_rd_s)      w_next = RD_CMD;
            else if (w_init && w_wr_s) w_next = WR_CMD;
         end
         RD_CMD:  w_next = RD_WAIT;
         RD_WAIT: if (w_last || w_timeout) w_next = DONE;
         WR_CMD:  w_next = WR_WAIT;
         WR_WAIT: if (w_wr_end) w_next = DONE;
         DONE:    if (!w_strobe) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (w_abort) w_next = DONE;
   end

   always_comb begin
      w_cmd_en   = 1'b0;
      w_drive    = 1'b0;
      w_wr_drive = 1'b0;
      w_mask     = MASK_NONE;
      case (r_state)
         RD_CMD: begin
            w_cmd_en = 1'b1;
            w_drive  = 1'b1;
         end
         WR_CMD: begin
            w_cmd_en   = 1'b1;
            w_drive    = 1'b1;
            w_wr_drive = 1'b1;
            w_mask     = byte_mask(r_byte, r_a0);
         end
         RD_WAIT, WR_WAIT, DONE: w_drive = 1'b1;
         default: ;
      endcase
   end

   // Beats are counted only in RD_WAIT of an unaborted read; later stray beats are dropped.
   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         r_ch    <= 1'b0;
         r_dir   <= CMD_RD;
         r_byte  <= 1'b0;
         r_a0    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_timer <= '0;
         r_beats <= '0;
      end else begin
         r_ack <= (w_next == DONE);
         if (r_state == IDLE) begin
            if (w_next != IDLE) begin
               r_ch    <= w_req_ch;
               r_dir   <= w_rd_s ? CMD_RD : CMD_WR;
               r_addr  <= bus.req_addr[MC_AW:1];
               r_wdata <= bus.req_wdata;
               r_byte  <= bus.req_byte;
               r_a0    <= bus.req_addr[0];
               r_err   <= 1'b0;
               r_timer <= '0;
               r_beats <= '0;
            end
         end else if (w_abort) begin
            r_err <= 1'b1;
         end else if (r_state == RD_WAIT) begin
            r_timer <= r_timer + 1'b1;
            if (w_beat) begin
               r_beats <= r_beats + 1'b1;
               if (r_beats == '0) r_rdata <= w_beat_data;
            end
            if (w_timeout && !w_last) begin
               r_err   <= 1'b1;
               r_rdata <= ERR_DATA;
            end
         end else if (r_state == WR_WAIT) begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic w_hit;
      assign w_hit = (r_ch == 1'(g));
      assign bus.mc_cmd[g]                    = w_hit && w_drive && r_dir;
      assign bus.mc_cmd_en[g]                 = w_hit && w_cmd_en;
      assign bus.mc_addr[g*MC_AW +: MC_AW]    = (w_hit && w_drive) ? r_addr : '0;
      assign bus.mc_wr_data[g*32 +: 32]       = (w_hit && w_wr_drive) ? {r_wdata, 16'h0000} : '0;
      assign bus.mc_data_mask[g*4 +: 4]       = w_hit ? w_mask : MASK_NONE;
      assign w_ch_valid[g]                    = bus.mc_rd_valid[g];
      assign w_ch_calib[g]                    = bus.mc_init_calib[g];
      assign w_ch_rdata[g]                    = bus.mc_rd_data[g*32+16 +: 16];
   end

   assign bus.rdata = r_rdata;
   assign bus.ack   = r_ack;
   assign bus.err   = r_err;
   assign bus.init  = w_init;
endmodule

// File: tb/tb_psram_bus_bridge.sv
// tb/tb_psram_bus_bridge.sv - directed self-checking bench for psram_bus_bridge
module tb_psram_bus_bridge;
   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   psram_bus_bridge_if #(.NCH(2), .ADDR_W(23), .MC_AW(21)) bus ();

   psram_bus_bridge dut (
      .clk_out (clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1);
   end

   task automatic wait_cmd_en(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.mc_cmd_en === 2'b00 && n <= limit);
   endtask

   task automatic wait_ack(input logic lvl, input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.ack !== lvl && n <= limit);
   endtask

   // Controller model: one idle cycle after the command, then four consecutive beats.
   task automatic drive_beats(input int ch, input logic [31:0] d0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.mc_rd_valid[ch] = 1'b1;
         bus.mc_rd_data[ch*32 +: 32] = d0 + 32'(i);
         @(negedge clk);
      end
      bus.mc_rd_valid = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_rd = 1'b0;
      bus.req_wr = 1'b0;
      bus.req_byte = 1'b0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      bus.mc_rd_data = '0;
      bus.mc_rd_valid = 2'b00;
      bus.mc_init_calib = 2'b11;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.rdata !== 16'h0 || bus.ack !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_cpu: rdata=%h ack=%b err=%b want 0000/0/0", bus.rdata, bus.ack, bus.err);
      end
      checks++;
      if (bus.mc_cmd !== 2'b00 || bus.mc_cmd_en !== 2'b00 || bus.mc_addr !== 42'h0 ||
          bus.mc_wr_data !== 64'h0 || bus.mc_data_mask !== 8'hFF) begin
         errors++;
         $display("FAIL reset_mc: cmd=%b en=%b addr=%h wd=%h mask=%h", bus.mc_cmd, bus.mc_cmd_en,
                  bus.mc_addr, bus.mc_wr_data, bus.mc_data_mask);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word_write();
      int n, k, pulses;
      logic [7:0] mask_after;
      bus.req_addr = 23'h000124;
      bus.req_wdata = 16'hBEEF;
      bus.req_byte = 1'b0;
      bus.req_wr = 1'b1;
      wait_cmd_en(10, n);
      checks++;
      if (n !== 3) begin errors++; $display("FAIL wr_cmd_latency: got %0d want 3", n); end
      checks++;
      if (bus.mc_cmd_en !== 2'b01 || bus.mc_cmd[0] !== 1'b1) begin
         errors++; $display("FAIL wr_cmd: en=%b cmd=%b want 01/x1", bus.mc_cmd_en, bus.mc_cmd);
      end
      checks++;
      if (bus.mc_addr[20:0] !== 21'h92) begin
         errors++; $display("FAIL wr_addr: got %h want 000092", bus.mc_addr[20:0]);
      end
      checks++;
      if (bus.mc_wr_data[31:0] !== 32'hBEEF0000) begin
         errors++; $display("FAIL wr_data: got %h want BEEF0000", bus.mc_wr_data[31:0]);
      end
      checks++;
      if (bus.mc_data_mask[3:0] !== 4'b0011) begin
         errors++; $display("FAIL wr_word_mask: got %b want 0011", bus.mc_data_mask[3:0]);
      end
      checks++;
      if (bus.mc_data_mask[7:4] !== 4'hF || bus.mc_wr_data[63:32] !== 32'h0 || bus.mc_addr[41:21] !== 21'h0) begin
         errors++; $display("FAIL wr_ch1_idle: mask=%b wd=%h addr=%h want 1111/0/0",
                            bus.mc_data_mask[7:4], bus.mc_wr_data[63:32], bus.mc_addr[41:21]);
      end
      k = 0;
      pulses = 0;
      mask_after = 8'h00;
      do begin
         @(negedge clk);
         k++;
         if (k == 1) mask_after = bus.mc_data_mask;
         if (bus.mc_cmd_en !== 2'b00) pulses++;
      end while (bus.ack !== 1'b1 && k < 40);
      checks++;
      if (k !== 14) begin errors++; $display("FAIL wr_ack_latency: got %0d want 14", k); end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL wr_single_pulse: extra pulses %0d want 0", pulses); end
      checks++;
      if (mask_after !== 8'hFF) begin errors++; $display("FAIL wr_mask_release: got %h want FF", mask_after); end
      bus.req_wr = 1'b0;
      wait_ack(1'b0, 10, n);
      checks++;
      if (n !== 3) begin errors++; $display("FAIL wr_ack_drop: got %0d want 3", n); end
   endtask

   task automatic test_byte_write();
      logic [22:0] addrs [2] = '{23'h000125, 23'h000124};
      logic [3:0]  masks [2] = '{4'b0111, 4'b1011};
      int n;
      for (int i = 0; i < 2; i++) begin
         bus.req_addr = addrs[i];
         bus.req_wdata = 16'h00A5;
         bus.req_byte = 1'b1;
         bus.req_wr = 1'b1;
         wait_cmd_en(10, n);
         checks++;
         if (bus.mc_data_mask !== {4'hF, masks[i]}) begin
            errors++; $display("FAIL byte_mask_%0d: got %b want %b", i, bus.mc_data_mask, {4'hF, masks[i]});
         end
         @(negedge clk);
         checks++;
         if (bus.mc_data_mask !== 8'hFF) begin
            errors++; $display("FAIL byte_mask_release_%0d: got %h want FF", i, bus.mc_data_mask);
         end
         wait_ack(1'b1, 20, n);
         bus.req_wr = 1'b0;
         wait_ack(1'b0, 10, n);
      end
      bus.req_byte = 1'b0;
   endtask

   task automatic test_read();
      int n;
      logic ack_last;
      bus.req_addr = 23'h400010;
      bus.req_rd = 1'b1;
      wait_cmd_en(10, n);
      checks++;
      if (n !== 3 || bus.mc_cmd_en !== 2'b10 || bus.mc_cmd !== 2'b00) begin
         errors++; $display("FAIL rd_cmd: lat=%0d en=%b cmd=%b want 3/10/00", n, bus.mc_cmd_en, bus.mc_cmd);
      end
      checks++;
      if (bus.mc_addr[41:21] !== 21'h8) begin
         errors++; $display("FAIL rd_addr: got %h want 000008", bus.mc_addr[41:21]);
      end
      @(negedge clk);
      bus.mc_rd_valid = 2'b11;
      bus.mc_rd_data = {32'h12345678, 32'hDEAD0000};
      @(negedge clk);
      bus.mc_rd_valid = 2'b10;
      bus.mc_rd_data[63:32] = 32'h11112222;
      @(negedge clk);
      bus.mc_rd_data[63:32] = 32'h33334444;
      @(negedge clk);
      bus.mc_rd_data[63:32] = 32'h55556666;
      ack_last = bus.ack;
      @(negedge clk);
      bus.mc_rd_valid = 2'b00;
      checks++;
      if (ack_last !== 1'b0 || bus.ack !== 1'b1) begin
         errors++; $display("FAIL rd_ack_timing: last_beat=%b after=%b want 0/1", ack_last, bus.ack);
      end
      checks++;
      if (bus.rdata !== 16'h1234 || bus.err !== 1'b0) begin
         errors++; $display("FAIL rd_data: rdata=%h err=%b want 1234/0", bus.rdata, bus.err);
      end
      bus.req_rd = 1'b0;
      wait_ack(1'b0, 10, n);
      checks++;
      if (n !== 3) begin errors++; $display("FAIL rd_ack_drop: got %0d want 3", n); end
   endtask

   task automatic test_timeout();
      int n;
      bus.req_addr = 23'h000200;
      bus.req_rd = 1'b1;
      wait_cmd_en(10, n);
      wait_ack(1'b1, 100, n);
      checks++;
      if (n !== 64) begin errors++; $display("FAIL timeout_latency: got %0d want 64", n); end
      checks++;
      if (bus.err !== 1'b1 || bus.rdata !== 16'hFFFF) begin
         errors++; $display("FAIL timeout_err: err=%b rdata=%h want 1/FFFF", bus.err, bus.rdata);
      end
      bus.req_rd = 1'b0;
      wait_ack(1'b0, 10, n);
   endtask

   task automatic test_back_to_back();
      int n;
      bus.req_addr = 23'h000300;
      bus.req_wdata = 16'h1111;
      bus.req_rd = 1'b1;
      bus.req_wr = 1'b1;
      wait_cmd_en(10, n);
      checks++;
      if (n !== 3 || bus.mc_cmd_en !== 2'b01 || bus.mc_cmd[0] !== 1'b0) begin
         errors++; $display("FAIL both_rd_first: lat=%0d en=%b cmd=%b want 3/01/read", n, bus.mc_cmd_en, bus.mc_cmd);
      end
      drive_beats(0, 32'hCAFE0000);
      checks++;
      if (bus.ack !== 1'b1 || bus.rdata !== 16'hCAFE || bus.err !== 1'b0) begin
         errors++; $display("FAIL both_rd_done: ack=%b rdata=%h err=%b want 1/CAFE/0", bus.ack, bus.rdata, bus.err);
      end
      bus.req_rd = 1'b0;
      wait_cmd_en(12, n);
      checks++;
      if (n !== 4 || bus.mc_cmd[0] !== 1'b1 || bus.mc_wr_data[31:0] !== 32'h11110000) begin
         errors++; $display("FAIL both_wr_next: lat=%0d cmd=%b wd=%h want 4/write/11110000",
                            n, bus.mc_cmd, bus.mc_wr_data[31:0]);
      end
      wait_ack(1'b1, 30, n);
      checks++;
      if (n !== 14) begin errors++; $display("FAIL both_wr_ack: got %0d want 14", n); end
      bus.req_wr = 1'b0;
      wait_ack(1'b0, 10, n);
   endtask

   task automatic test_reset_mid();
      int n, pulses;
      bus.req_addr = 23'h000040;
      bus.req_rd = 1'b1;
      wait_cmd_en(10, n);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.rdata !== 16'h0 || bus.ack !== 1'b0 || bus.err !== 1'b0 || bus.mc_cmd_en !== 2'b00 ||
          bus.mc_addr !== 42'h0 || bus.mc_data_mask !== 8'hFF || bus.mc_cmd !== 2'b00) begin
         errors++; $display("FAIL midreset_outputs: rdata=%h ack=%b err=%b en=%b addr=%h mask=%h",
                            bus.rdata, bus.ack, bus.err, bus.mc_cmd_en, bus.mc_addr, bus.mc_data_mask);
      end
      bus.req_rd = 1'b0;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.mc_cmd_en !== 2'b00) pulses++;
      end
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (bus.mc_cmd_en !== 2'b00) pulses++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL midreset_reissue: pulses=%0d want 0", pulses); end
      bus.req_addr = 23'h400020;
      bus.req_rd = 1'b1;
      wait_cmd_en(10, n);
      checks++;
      if (n !== 3 || bus.mc_cmd_en !== 2'b10) begin
         errors++; $display("FAIL postreset_cmd: lat=%0d en=%b want 3/10", n, bus.mc_cmd_en);
      end
      drive_beats(1, 32'h5A5A0001);
      checks++;
      if (bus.ack !== 1'b1 || bus.rdata !== 16'h5A5A || bus.err !== 1'b0) begin
         errors++; $display("FAIL postreset_read: ack=%b rdata=%h err=%b want 1/5A5A/0", bus.ack, bus.rdata, bus.err);
      end
      bus.req_rd = 1'b0;
      wait_ack(1'b0, 10, n);
   endtask

   task automatic test_init_gating();
      int n, pulses;
      bus.mc_init_calib = 2'b01;
      bus.req_addr = 23'h000010;
      bus.req_wdata = 16'h7777;
      bus.req_wr = 1'b1;
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.mc_cmd_en !== 2'b00) pulses++;
      end
      checks++;
      if (pulses !== 0 || bus.init !== 1'b0) begin
         errors++; $display("FAIL init_gate: pulses=%0d init=%b want 0/0", pulses, bus.init);
      end
      bus.mc_init_calib = 2'b11;
      wait_cmd_en(10, n);
      checks++;
      if (n < 1 || n > 3 || bus.init !== 1'b1 || bus.mc_cmd_en !== 2'b01 || bus.mc_cmd[0] !== 1'b1) begin
         errors++; $display("FAIL init_release: lat=%0d init=%b en=%b want <=3/1/01", n, bus.init, bus.mc_cmd_en);
      end
      repeat (3) @(negedge clk);
      bus.mc_init_calib = 2'b10;
      @(negedge clk);
      checks++;
      if (bus.ack !== 1'b1 || bus.err !== 1'b1) begin
         errors++; $display("FAIL calib_abort: ack=%b err=%b want 1/1", bus.ack, bus.err);
      end
      bus.mc_init_calib = 2'b11;
      bus.req_wr = 1'b0;
      wait_ack(1'b0, 10, n);
      checks++;
      if (n !== 3 || bus.err !== 1'b1) begin
         errors++; $display("FAIL calib_abort_hold: drop=%0d err=%b want 3/1", n, bus.err);
      end
   endtask

   initial begin
      test_reset();
      test_word_write();
      test_byte_write();
      test_read();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_init_gating();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
